frame_irq_controller: RTL and testbench
=======================================

Name: frame_irq_controller

Overview:
Parametrised successor of the single-key input interrupt controller. Generates a periodic frame-ready interrupt and up to NUM_KEYS key interrupts.
- Each source latches into its own pending bit.
- The highest-priority pending source is presented to the CPU as a 32-bit interrupt instruction, under a valid/ack handshake.
- Sits between the board key inputs and the processor's interrupt-instruction injection point.

Parameters:
NUM_KEYS, 4, number of key channels (1..31).
FRAME_DIV, 50000000, proc_clk cycles per frame tick (>=2).
CNT_W, 32, frame counter width; must hold FRAME_DIV-1.

Ports:
proc_clk  in  1  processor clock; all logic on rising edge.
reset  in  1  synchronous, active-high reset.
key_in  in  NUM_KEYS  raw asynchronous key levels.
key_en  in  NUM_KEYS  per-key enable; 0 blocks new key events.
frame_en  in  1  0 blocks new frame events (counter keeps running).
irq_ack  in  1  CPU accepts the presented instruction.
irq_valid  out  1  an instruction is presented.
irq_instr  out  32  interrupt instruction; 32'b0 whenever irq_valid=0.
frame_overrun  out  1  one-cycle pulse: frame event lost.
overrun_cnt  out  8  saturating count of lost frame events.

Behaviour:
- Reset (synchronous, proc_clk edge with reset=1) clears:
  - frame counter, sync/edge flops, all pending bits and FSM state (to IDLE);
  - irq_valid=0, irq_instr=0, frame_overrun=0, overrun_cnt=0.
  - Reset mid-presentation drops the presented and all pending events; nothing is replayed.
- Frame counter:
  - Counts 0..FRAME_DIV-1, then wraps to 0.
  - tick=1 combinationally when count==FRAME_DIV-1, so the period is exactly FRAME_DIV cycles.
  - The first tick is at the FRAME_DIV-th edge after reset release.
- Key path, per key:
  - sync1 <= key_in; sync2 <= sync1; prev <= sync2.
  - Event = sync2 & ~prev & key_en.
  - A key sampled high at edge E sets its pending bit at edge E+2. The earliest irq_valid is after edge E+3.
  - Flops reset to 0, so a key held high through reset yields one event.
  - Only rising edges count; holding a key produces no further events.
- Pending bits: pend[0]=frame, pend[k+1]=key k.
  - Set by event, cleared by accept of that source.
  - Event and accept on the same source in the same cycle: event wins, bit stays set.
  - Key event while its bit is already set: merged silently.
  - Frame event (tick & frame_en) while pend[0]=1: frame_overrun=1 next cycle and overrun_cnt += 1, saturating at 255.
- Priority: key 0 highest, then ascending key index, frame lowest.
- FSM, 2 states:
  - IDLE: irq_valid=0. If any pend bit is set, register sel=highest-priority source, irq_instr=build(sel), irq_valid=1, go to PRESENT.
  - PRESENT: irq_instr and sel are held stable regardless of new events.
    - If irq_ack=1, clear pend[sel] (subject to event-wins), irq_valid=0, irq_instr=0, go to IDLE.
    - irq_ack while irq_valid=0 is ignored.
- Throughput: at most one instruction every 2 cycles; one IDLE cycle between back-to-back presentations.
- Instruction format:
  - [31:27]=IRQ_OPCODE, [26:5]=0, [4:0]=source id.
  - Source id: 0=frame, k+1=key k.
- key_en/frame_en deassertion does not clear bits already pending.

Decomposition:
- Package frame_irq_pkg:
  - IRQ_OPCODE (5'b10110), SRC_W=5, SRC_FRAME=0.
  - Function build_irq_instr(src_id) returning 32 bits.
  - FSM state enum {IDLE, PRESENT}.
- Sub-module key_sync_edge (width NUM_KEYS): 2-flop synchroniser, prev register and rising-edge detect, with synchronous reset to 0. Instantiated once.
- Counter, pending vector, priority encoder and FSM stay in the top module.

Test Plan:
1. FRAME_DIV=8, NUM_KEYS=4, keys low, irq_ack tied 1, reset released -> irq_valid first high after the 9th edge, then one-cycle pulses every 8 cycles, irq_instr=32'hB0000000 (src 0).
2. key_in[2] rises at edge E, irq_ack=0 -> irq_valid high after E+3, irq_instr=32'hB0000003, held stable 10 cycles; ack at cycle 10 -> valid 0 next cycle, pend[3] cleared.
3. key_in[0] and key_in[3] rise together, frame tick same cycle, ack=1 -> presented order src 1, 4, 0, with one IDLE cycle between each.
4. FRAME_DIV=8, frame presented, ack held 0 for 20 cycles -> two frame_overrun pulses, overrun_cnt=2, exactly one frame instruction delivered after ack.
5. key_en[1]=0 while key_in[1] toggles 3 times -> no src-2 instruction. Then key_en[1]=1 with a held-high key -> still none until the next rising edge.
6. Assert reset during PRESENT with pend[0] and pend[2] set -> after that edge irq_valid=0, irq_instr=0; neither event is replayed after release. Separately, 300 forced overruns -> overrun_cnt=255.

Source files
------------

// File: rtl/frame_irq_controller_pkg.sv
// Shared constants, FSM state type and instruction builder for the frame/key
// interrupt controller.
package frame_irq_pkg;

    localparam logic [4:0] IRQ_OPCODE = 5'b10110;
    localparam int         SRC_W      = 5;
    localparam logic [SRC_W-1:0] SRC_FRAME = '0;

    typedef enum logic {
        IDLE,
        PRESENT
    } irq_state_e;

    // Opcode in the top five bits, source id in the bottom five, zeros between.
    function automatic logic [31:0] build_irq_instr(input logic [SRC_W-1:0] src_id);
        return {IRQ_OPCODE, 22'b0, src_id};
    endfunction

endpackage

// File: rtl/frame_irq_controller_if.sv
// Interrupt-instruction handshake between the controller (master) and the
// CPU injection point (slave).
interface frame_irq_if;

    logic        irq_valid;
    logic        irq_ack;
    logic [31:0] irq_instr;

    modport master (
        output irq_valid,
        output irq_instr,
        input  irq_ack
    );

    modport slave (
        input  irq_valid,
        input  irq_instr,
        output irq_ack
    );

endinterface

// File: rtl/frame_irq_controller_key_sync_edge.sv
// Two-flop synchroniser plus previous-value register per key; flags one-cycle
// rising edges of the synchronised level.
module key_sync_edge #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_key,
    output logic [WIDTH-1:0] o_rise
);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_prev;

    // NOTE: non-blocking assignments let each stage sample the previous
    // stage's old value, forming a true shift chain.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
        end else begin
            r_sync1 <= i_key;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign o_rise = r_sync2 & ~r_prev;

endmodule

// File: rtl/frame_irq_controller.sv
// Frame-tick and key interrupt controller: latches events into pending bits
// and presents the highest-priority one as an interrupt instruction.
module frame_irq_controller
    import frame_irq_pkg::*;
#(
    parameter int NUM_KEYS  = 4,
    parameter int FRAME_DIV = 50000000,
    parameter int CNT_W     = 32
) (
    input  logic                proc_clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_in,
    input  logic [NUM_KEYS-1:0] key_en,
    input  logic                frame_en,
    frame_irq_if.master         irq_bus,
    output logic                frame_overrun,
    output logic [7:0]          overrun_cnt
);

    localparam int              NSRC     = NUM_KEYS + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_DIV - 1);

    logic [CNT_W-1:0]    r_cnt;
    logic                w_tick;
    logic [NUM_KEYS-1:0] w_key_rise;
    logic [NSRC-1:0]     r_pend;
    logic [NSRC-1:0]     w_event;
    logic [NSRC-1:0]     w_clear;
    logic                w_accept;
    logic                w_frame_lost;
    logic [SRC_W-1:0]    w_pick;
    logic [SRC_W-1:0]    r_sel;
    irq_state_e          r_state;
    logic                r_valid;
    logic [31:0]         r_instr;
    logic                r_overrun;
    logic [7:0]          r_overrun_cnt;

    key_sync_edge #(
        .WIDTH (NUM_KEYS)
    ) u_key_sync_edge (
        .i_clk   (proc_clk),
        .i_reset (reset),
        .i_key   (key_in),
        .o_rise  (w_key_rise)
    );

    always_ff @(posedge proc_clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_tick   = (r_cnt == CNT_LAST);
    assign w_event  = {w_key_rise & key_en, w_tick & frame_en};
    assign w_accept = (r_state == PRESENT) && irq_bus.irq_ack;

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned and a latch is never inferred.
    always_comb begin
        w_clear = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (w_accept && (r_sel == SRC_W'(i))) begin
                w_clear[i] = 1'b1;
            end
        end
    end

    // Descending scan: the lowest-numbered key that is pending wins; the
    // frame source is the fallback.
    always_comb begin
        w_pick = SRC_FRAME;
        for (int k = NUM_KEYS; k >= 1; k--) begin
            if (r_pend[k]) begin
                w_pick = SRC_W'(k);
            end
        end
    end

    // A frame event merged into a bit that is not being accepted this cycle
    // is the only way a frame is lost.
    assign w_frame_lost = w_event[0] & r_pend[0] & ~w_clear[0];

    always_ff @(posedge proc_clk) begin
        if (reset) begin
            r_pend <= '0;
        end else begin
            r_pend <= (r_pend & ~w_clear) | w_event;
        end
    end

    always_ff @(posedge proc_clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_sel   <= SRC_FRAME;
            r_valid <= 1'b0;
            r_instr <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|r_pend) begin
                        r_sel   <= w_pick;
                        r_instr <= build_irq_instr(w_pick);
                        r_valid <= 1'b1;
                        r_state <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (irq_bus.irq_ack) begin
                        r_valid <= 1'b0;
                        r_instr <= '0;
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge proc_clk) begin
        if (reset) begin
            r_overrun     <= 1'b0;
            r_overrun_cnt <= '0;
        end else begin
            r_overrun <= w_frame_lost;
            if (w_frame_lost && (r_overrun_cnt != 8'hFF)) begin
                r_overrun_cnt <= r_overrun_cnt + 8'd1;
            end
        end
    end

    assign irq_bus.irq_valid = r_valid;
    assign irq_bus.irq_instr = r_instr;
    assign frame_overrun     = r_overrun;
    assign overrun_cnt       = r_overrun_cnt;

endmodule

// File: tb/tb_frame_irq_controller.sv
// Directed bench for frame_irq_controller with an event-level reference model
// compared on every cycle, plus hand-computed expectations per scenario.
module tb_frame_irq_controller;

    localparam int NK = 4;
    localparam int FD = 8;

    logic          proc_clk = 1'b0;
    logic          reset    = 1'b0;
    logic [NK-1:0] key_in   = '0;
    logic [NK-1:0] key_en   = '0;
    logic          frame_en = 1'b0;
    logic          frame_overrun;
    logic [7:0]    overrun_cnt;

    frame_irq_if bus ();

    frame_irq_controller #(
        .NUM_KEYS  (NK),
        .FRAME_DIV (FD),
        .CNT_W     (8)
    ) dut (
        .proc_clk      (proc_clk),
        .reset         (reset),
        .key_in        (key_in),
        .key_en        (key_en),
        .frame_en      (frame_en),
        .irq_bus       (bus),
        .frame_overrun (frame_overrun),
        .overrun_cnt   (overrun_cnt)
    );

    always #5 proc_clk = ~proc_clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: edges counted from reset release; sources are plain
    // pending flags; a presentation is a (source, active) pair.
    int          edge_no = 0;
    bit          m_live  = 0;
    bit [NK:0]   m_pend;
    bit          m_pres;
    int          m_src;
    bit          m_ovf;
    int          m_cnt;
    logic [NK-1:0] h1, h2, h3;  // key samples taken 1, 2, 3 edges ago

    task automatic model_step();
        bit [NK:0] ev;
        bit [NK:0] old;
        bit        acc;
        int        pick;
        if (reset) begin
            m_live = 1; edge_no = 0; m_pend = '0; m_pres = 0; m_src = 0;
            m_ovf = 0; m_cnt = 0; h1 = '0; h2 = '0; h3 = '0;
            return;
        end
        edge_no++;
        ev = '0;
        if (frame_en && (edge_no % FD == 0)) ev[0] = 1'b1;
        for (int k = 0; k < NK; k++)
            if (h2[k] && !h3[k] && key_en[k]) ev[k+1] = 1'b1;
        h3 = h2; h2 = h1; h1 = key_in;
        acc   = m_pres && bus.irq_ack;
        old   = m_pend;
        m_ovf = ev[0] && old[0] && !(acc && m_src == 0);
        if (m_ovf && m_cnt < 255) m_cnt++;
        if (acc) m_pend[m_src] = 1'b0;
        m_pend = m_pend | ev;
        if (m_pres) begin
            if (acc) m_pres = 0;
        end else if (old != '0) begin
            pick = 0;
            for (int i = NK; i >= 1; i--) if (old[i]) pick = i;
            m_pres = 1;
            m_src  = pick;
        end
    endtask

    always @(posedge proc_clk) model_step();

    always @(negedge proc_clk) begin
        if (m_live) begin
            check("cmp_valid", {31'b0, bus.irq_valid}, {31'b0, m_pres});
            check("cmp_instr", bus.irq_instr, m_pres ? (32'hB000_0000 | 32'(m_src)) : 32'h0);
            check("cmp_overrun", {31'b0, frame_overrun}, {31'b0, m_ovf});
            check("cmp_overrun_cnt", {24'b0, overrun_cnt}, 32'(m_cnt));
        end
    end

    task automatic do_reset();
        @(negedge proc_clk);
        reset = 1'b1;
        @(negedge proc_clk);
        @(negedge proc_clk);
        reset = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge proc_clk);
    endtask

    int          vedge[$];
    int          vsrc[$];
    int          pulses;
    int          rises;
    int          seen;
    bit          prev_v;
    bit          got;
    logic [31:0] cap;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: periodic frame interrupts with ack tied high
        key_en = '1; frame_en = 1'b1; bus.irq_ack = 1'b1;
        do_reset();
        check("rst_valid", {31'b0, bus.irq_valid}, 32'd0);
        check("rst_instr", bus.irq_instr, 32'd0);
        check("rst_overrun", {31'b0, frame_overrun}, 32'd0);
        check("rst_cnt", {24'b0, overrun_cnt}, 32'd0);
        vedge.delete();
        for (int i = 0; i < 26; i++) begin
            @(negedge proc_clk);
            if (bus.irq_valid) begin
                vedge.push_back(edge_no);
                check("t1_instr", bus.irq_instr, 32'hB000_0000);
            end
        end
        check("t1_count", 32'(vedge.size()), 32'd3);
        check("t1_first", 32'(vedge.size() > 0 ? vedge[0] : -1), 32'd9);
        check("t1_second", 32'(vedge.size() > 1 ? vedge[1] : -1), 32'd17);
        check("t1_third", 32'(vedge.size() > 2 ? vedge[2] : -1), 32'd25);

        // 2: key 2 presented and held until acked
        frame_en = 1'b0; bus.irq_ack = 1'b0;
        do_reset();
        step(2);
        key_in[2] = 1'b1;  // sampled at edge 3
        for (int i = 0; i < 3; i++) begin
            @(negedge proc_clk);
            check("t2_early", {31'b0, bus.irq_valid}, 32'd0);
        end
        @(negedge proc_clk);
        check("t2_valid", {31'b0, bus.irq_valid}, 32'd1);
        check("t2_instr", bus.irq_instr, 32'hB000_0003);
        for (int i = 0; i < 9; i++) begin
            @(negedge proc_clk);
            check("t2_hold", bus.irq_instr, 32'hB000_0003);
        end
        bus.irq_ack = 1'b1;
        @(negedge proc_clk);
        check("t2_acked", {31'b0, bus.irq_valid}, 32'd0);
        bus.irq_ack = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge proc_clk);
            if (bus.irq_valid) seen++;
        end
        check("t2_cleared", 32'(seen), 32'd0);
        key_in = '0;

        // 3: keys 0 and 3 plus a frame tick land on the same edge
        frame_en = 1'b1; bus.irq_ack = 1'b1;
        do_reset();
        step(5);
        key_in = 4'b1001;  // sampled at edge 6, pending at edge 8 with the frame
        vedge.delete(); vsrc.delete();
        for (int i = 0; i < 10; i++) begin
            @(negedge proc_clk);
            if (bus.irq_valid) begin
                vedge.push_back(edge_no);
                vsrc.push_back(int'(bus.irq_instr[4:0]));
            end
        end
        check("t3_count", 32'(vsrc.size()), 32'd3);
        check("t3_src_a", 32'(vsrc.size() > 0 ? vsrc[0] : -1), 32'd1);
        check("t3_src_b", 32'(vsrc.size() > 1 ? vsrc[1] : -1), 32'd4);
        check("t3_src_c", 32'(vsrc.size() > 2 ? vsrc[2] : -1), 32'd0);
        check("t3_edge_a", 32'(vedge.size() > 0 ? vedge[0] : -1), 32'd9);
        check("t3_edge_c", 32'(vedge.size() > 2 ? vedge[2] : -1), 32'd13);
        key_in = '0;

        // 4: frame held unacknowledged across two further ticks
        bus.irq_ack = 1'b0;
        do_reset();
        pulses = 0; rises = 0; prev_v = 0;
        for (int i = 0; i < 29; i++) begin
            @(negedge proc_clk);
            if (frame_overrun) pulses++;
            if (bus.irq_valid && !prev_v) rises++;
            prev_v = bus.irq_valid;
        end
        bus.irq_ack = 1'b1;
        @(negedge proc_clk);
        check("t4_acked", {31'b0, bus.irq_valid}, 32'd0);
        bus.irq_ack = 1'b0; frame_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge proc_clk);
            if (bus.irq_valid) rises++;
        end
        check("t4_pulses", 32'(pulses), 32'd2);
        check("t4_cnt", {24'b0, overrun_cnt}, 32'd2);
        check("t4_delivered", 32'(rises), 32'd1);

        // 5: disabled key toggles, then enable with the key already high
        bus.irq_ack = 1'b1; key_en = 4'b1101;
        do_reset();
        seen = 0;
        for (int t = 0; t < 3; t++) begin
            key_in[1] = 1'b1;
            for (int i = 0; i < 3; i++) begin
                @(negedge proc_clk); if (bus.irq_valid) seen++;
            end
            key_in[1] = 1'b0;
            for (int i = 0; i < 3; i++) begin
                @(negedge proc_clk); if (bus.irq_valid) seen++;
            end
        end
        key_in[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge proc_clk); if (bus.irq_valid) seen++;
        end
        key_en = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            @(negedge proc_clk); if (bus.irq_valid) seen++;
        end
        check("t5_blocked", 32'(seen), 32'd0);
        key_in[1] = 1'b0;
        step(3);
        key_in[1] = 1'b1;
        got = 0; cap = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge proc_clk);
            if (bus.irq_valid && !got) begin got = 1; cap = bus.irq_instr; end
        end
        check("t5_fresh_edge", {31'b0, got}, 32'd1);
        check("t5_instr", cap, 32'hB000_0002);
        key_in = '0;

        // 6a: reset while presenting key 1 with the frame also pending
        bus.irq_ack = 1'b0; frame_en = 1'b1;
        do_reset();
        step(5);
        key_in[1] = 1'b1;
        step(4);
        check("t6_presenting", bus.irq_instr, 32'hB000_0002);
        reset = 1'b1; key_in = '0; frame_en = 1'b0;
        @(negedge proc_clk);
        check("t6_rst_valid", {31'b0, bus.irq_valid}, 32'd0);
        check("t6_rst_instr", bus.irq_instr, 32'd0);
        @(negedge proc_clk);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge proc_clk); if (bus.irq_valid) seen++;
        end
        check("t6_no_replay", 32'(seen), 32'd0);

        // 6b: 300 lost frames saturate the counter
        frame_en = 1'b1;
        do_reset();
        pulses = 0;
        for (int i = 0; i < 2410; i++) begin
            @(negedge proc_clk); if (frame_overrun) pulses++;
        end
        check("t6_pulses", 32'(pulses), 32'd300);
        check("t6_saturated", {24'b0, overrun_cnt}, 32'd255);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
